// File: rtl/collatz_if.sv
// collatz_if: seed-load, control and byte-read bus of the Collatz orbit engine.
interface collatz_if #(parameter int WIDTH = 144);
   localparam int AW = $clog2(WIDTH / 8);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          start;
   logic          abort;
   logic [1:0]    rd_sel;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          busy;
   logic          done;
   modport master (output wr_en, wr_addr, wr_data, start, abort, rd_sel, rd_addr,
                   input rd_data, busy, done);
   modport slave  (input wr_en, wr_addr, wr_data, start, abort, rd_sel, rd_addr,
                   output rd_data, busy, done);
endinterface

// File: rtl/collatz_engine.sv
// collatz_engine: iterates a byte-loaded seed along its Collatz orbit, tracking
// orbit length, the peak of the top bits, and zero/overflow/timeout termination.
module collatz_engine #(
   parameter int WIDTH    = 144,
   parameter int OLEN_W   = 16,
   parameter int REC_W    = 16,
   parameter int SHORTCUT = 1
) (
   input logic       clk,
   input logic       rst_n,
   collatz_if.slave  bus
);
   localparam int NB = WIDTH / 8;
   typedef enum logic {IDLE, RUN} state_t;
   state_t              r_state, w_state_nxt;
   logic [WIDTH-1:0]    r_iter;
   logic [OLEN_W-1:0]   r_count;
   logic [REC_W-1:0]    r_rec;
   logic                r_err_zero, r_timeout, r_overflow, r_done;
   logic [7:0]          r_rd_data;
   logic [WIDTH+1:0]    w_tri;
   logic [WIDTH-1:0]    w_next;
   logic [OLEN_W:0]     w_cnt_inc;
   logic [REC_W-1:0]    w_cand, w_rec_nxt;
   logic [1:0]          w_inc;
   logic [7:0]          w_rd;
   logic                w_odd, w_ovf, w_tmo, w_wr, w_start, w_step, w_fin;
   logic                w_set_zero, w_set_ovf, w_set_tmo;

   assign w_odd     = r_iter[0];
   assign w_tri     = {2'b00, r_iter} + {1'b0, r_iter, 1'b0} + (WIDTH+2)'(1);
   assign w_ovf     = w_odd && (w_tri[WIDTH+1:WIDTH] != 2'b00);
   assign w_inc     = (SHORTCUT != 0 && w_odd) ? 2'd2 : 2'd1;
   assign w_cnt_inc = {1'b0, r_count} + (OLEN_W+1)'(w_inc);
   assign w_tmo     = w_cnt_inc[OLEN_W];
   assign w_next    = !w_odd ? r_iter >> 1 : (SHORTCUT != 0) ? w_tri[WIDTH:1] : w_tri[WIDTH-1:0];
   // On odd steps 3n+1 is never below the stored next value, so it alone can raise the record
   assign w_cand    = w_odd ? w_tri[WIDTH-1 -: REC_W] : w_next[WIDTH-1 -: REC_W];
   assign w_rec_nxt = (w_cand > r_rec) ? w_cand : r_rec;
   assign w_wr      = bus.wr_en && !bus.start && r_state == IDLE && (32'(bus.wr_addr) < NB);

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_step      = 1'b0;
      w_fin       = 1'b0;
      w_set_zero  = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_tmo   = 1'b0;
      if (r_state == IDLE) begin
         w_start     = bus.start;
         w_state_nxt = bus.start ? RUN : IDLE;
      end else if (bus.abort) begin
         w_state_nxt = IDLE;
      end else begin
         w_set_zero  = r_iter == '0;
         w_set_ovf   = w_ovf;
         w_set_tmo   = r_iter > WIDTH'(1) && !w_ovf && w_tmo;
         w_step      = r_iter > WIDTH'(1) && !w_ovf && !w_tmo;
         w_fin       = !w_step;
         w_state_nxt = w_step ? RUN : IDLE;
      end
   end

   assign w_rd = (bus.rd_sel == 2'd0) ? 8'(r_iter >> {bus.rd_addr, 3'b000}) :
                 (bus.rd_sel == 2'd1) ? 8'(r_count >> {bus.rd_addr, 3'b000}) :
                 (bus.rd_sel == 2'd2) ? 8'(r_rec >> {bus.rd_addr, 3'b000}) :
                 (bus.rd_addr == '0)  ? {5'b0, r_err_zero, r_timeout, r_overflow} : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iter     <= '0;
         r_count    <= '0;
         r_rec      <= '0;
         r_err_zero <= 1'b0;
         r_timeout  <= 1'b0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         r_rd_data  <= 8'h00;
      end else begin
         r_done    <= w_fin;
         r_rd_data <= w_rd;
         if (w_wr) r_iter[8*bus.wr_addr +: 8] <= bus.wr_data;
         if (w_start) begin
            r_count    <= '0;
            r_rec      <= r_iter[WIDTH-1 -: REC_W];
            r_err_zero <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
         end
         if (w_step) begin
            r_iter  <= w_next;
            r_count <= w_cnt_inc[OLEN_W-1:0];
            r_rec   <= w_rec_nxt;
         end
         if (w_set_zero) r_err_zero <= 1'b1;
         if (w_set_ovf) r_overflow <= 1'b1;
         if (w_set_tmo) r_timeout <= 1'b1;
      end
   end

   assign bus.busy    = r_state == RUN;
   assign bus.done    = r_done;
   assign bus.rd_data = r_rd_data;
endmodule

// File: tb/tb_collatz_engine.sv
// tb_collatz_engine: three engine configurations driven in lockstep, checked against
// spec-derived vectors and an arithmetic orbit model.
module tb_collatz_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   collatz_if #(.WIDTH(16)) ia();
   collatz_if #(.WIDTH(16)) ib();
   collatz_if #(.WIDTH(32)) ic();

   logic       wr_en, start, abort;
   logic [1:0] wr_addr, rd_sel, rd_addr;
   logic [7:0] wr_data;

   assign ia.wr_en = wr_en && !wr_addr[1];
   assign ib.wr_en = wr_en && !wr_addr[1];
   assign ic.wr_en = wr_en;
   assign ia.wr_addr = wr_addr[0];
   assign ib.wr_addr = wr_addr[0];
   assign ic.wr_addr = wr_addr;
   assign ia.wr_data = wr_data;
   assign ib.wr_data = wr_data;
   assign ic.wr_data = wr_data;
   assign ia.start = start;
   assign ib.start = start;
   assign ic.start = start;
   assign ia.abort = abort;
   assign ib.abort = abort;
   assign ic.abort = abort;
   assign ia.rd_sel = rd_sel;
   assign ib.rd_sel = rd_sel;
   assign ic.rd_sel = rd_sel;
   assign ia.rd_addr = rd_addr[0];
   assign ib.rd_addr = rd_addr[0];
   assign ic.rd_addr = rd_addr;

   collatz_engine #(.WIDTH(16), .OLEN_W(16), .REC_W(16), .SHORTCUT(0)) da (.clk(clk), .rst_n(rst_n), .bus(ia));
   collatz_engine #(.WIDTH(16), .OLEN_W(16), .REC_W(16), .SHORTCUT(1)) db (.clk(clk), .rst_n(rst_n), .bus(ib));
   collatz_engine #(.WIDTH(32), .OLEN_W(8),  .REC_W(16), .SHORTCUT(0)) dc (.clk(clk), .rst_n(rst_n), .bus(ic));

   int W[3] = '{16, 16, 32};
   int O[3] = '{16, 16, 8};
   int S[3] = '{0, 1, 0};
   string fld[6] = '{"cycles", "done", "iter", "count", "record", "status"};

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] g[3][6];
   longint mexp[6];

   typedef struct {
      logic [31:0] seed;
      longint cyc, cnt, rec, it, st;
   } vec_t;
   vec_t tv[5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] busy3();
      return {ic.busy, ib.busy, ia.busy};
   endfunction

   function automatic logic [2:0] done3();
      return {ic.done, ib.done, ia.done};
   endfunction

   function automatic logic [7:0] byte_of(input int k);
      return (k == 0) ? ia.rd_data : (k == 1) ? ib.rd_data : ic.rd_data;
   endfunction

   // Orbit evaluated straight from the termination and step rules, one evaluation per busy cycle
   function automatic void model(input int k, input longint seed, input int lim);
      longint n = seed, t, inc, rec, cnt = 0, st = 0, dn = 0, cyc = 0;
      int sh = W[k] - 16;
      rec = n >> sh;
      while (cyc < 100000) begin
         cyc++;
         if (lim > 0 && cyc == lim) break;
         if (n == 0) begin st = 4; dn = 1; break; end
         if (n == 1) begin dn = 1; break; end
         if (n % 2 == 1 && 3 * n + 1 >= (longint'(1) << W[k])) begin st = 1; dn = 1; break; end
         inc = (n % 2 == 1 && S[k] == 1) ? 2 : 1;
         if (cnt + inc > (longint'(1) << O[k]) - 1) begin st = 2; dn = 1; break; end
         if (n % 2 == 1) begin
            t = 3 * n + 1;
            if ((t >> sh) > rec) rec = t >> sh;
            n = (S[k] == 1) ? t / 2 : t;
         end else n = n / 2;
         if ((n >> sh) > rec) rec = n >> sh;
         cnt += inc;
      end
      mexp = '{cyc, dn, n, cnt, rec, st};
   endfunction

   task automatic read_all();
      logic [7:0] oor = 8'h00;
      logic [7:0] b;
      int nb;
      for (int k = 0; k < 3; k++) for (int r = 2; r < 6; r++) g[k][r] = '0;
      for (int sel = 0; sel < 4; sel++) begin
         for (int a = 0; a < 4; a++) begin
            rd_sel = 2'(sel);
            rd_addr = 2'(a);
            tick();
            for (int k = 0; k < 3; k++) begin
               nb = (sel == 0) ? W[k] / 8 : (sel == 1) ? O[k] / 8 : (sel == 2) ? 2 : 1;
               b = byte_of(k);
               if (a < nb) g[k][2 + sel] = g[k][2 + sel] | (64'(b) << (8 * a));
               else if (k == 2) oor = oor | b;
            end
         end
      end
      chk("dc_out_of_range_bytes", 64'(oor), 64'h0);
   endtask

   task automatic run(input logic [31:0] seed, input int lim);
      int cyc[3] = '{0, 0, 0};
      int dn[3] = '{0, 0, 0};
      int guard = 0;
      for (int a = 0; a < 4; a++) begin
         wr_en = 1'b1;
         wr_addr = 2'(a);
         wr_data = seed[8*a +: 8];
         tick();
      end
      wr_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (1) begin
         for (int k = 0; k < 3; k++) begin
            if (busy3()[k]) cyc[k]++;
            if (done3()[k]) dn[k]++;
         end
         if (busy3() == 3'b000) break;
         if (++guard > 5000) begin
            chk("busy_bound", 64'(busy3()), 64'h0);
            break;
         end
         abort = lim > 0 && cyc[0] == lim;
         wr_en = cyc[0] == 2 && busy3() == 3'b111;
         wr_addr = 2'd0;
         wr_data = 8'hFF;
         tick();
      end
      abort = 1'b0;
      wr_en = 1'b0;
      read_all();
      for (int k = 0; k < 3; k++) begin
         g[k][0] = 64'(cyc[k]);
         g[k][1] = 64'(dn[k]);
         model(k, (W[k] == 16) ? longint'(seed[15:0]) : longint'(seed), lim);
         for (int f = 0; f < 6; f++)
            chk($sformatf("d%0d_seed%0h_%s", k, seed, fld[f]), g[k][f], 64'(mexp[f]));
      end
   endtask

   task automatic chk_regs_zero(input string tag);
      read_all();
      for (int k = 0; k < 3; k++)
         for (int r = 2; r < 6; r++) chk($sformatf("%s_d%0d_%s", tag, k, fld[r]), g[k][r], 64'h0);
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy3()), 64'h0);
      chk({tag, "_done"}, 64'(done3()), 64'h0);
      chk({tag, "_rd_data"}, {40'h0, ia.rd_data, ib.rd_data, ic.rd_data}, 64'h0);
   endtask

   initial begin
      logic [31:0] seed;
      int lim, guard;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; abort = 1'b0;
      rd_sel = '0; rd_addr = '0;
      tv[0] = '{32'd27,     112, 111, 64'h2410, 1,        0};
      tv[1] = '{32'd1,      1,   0,   64'h0001, 1,        0};
      tv[2] = '{32'd0,      1,   0,   64'h0000, 0,        4};
      tv[3] = '{32'h0000AAAB, 1, 0,   64'hAAAB, 64'hAAAB, 1};
      tv[4] = '{32'd6,      9,   8,   64'h0010, 1,        0};
      #1;
      chk_outs_zero("reset");
      #11 rst_n = 1'b1;
      tick();
      chk_regs_zero("reset_regs");

      for (int i = 0; i < 5; i++) begin
         run(tv[i].seed, 0);
         chk($sformatf("vec%0d_cycles", i), g[0][0], 64'(tv[i].cyc));
         chk($sformatf("vec%0d_count", i), g[0][3], 64'(tv[i].cnt));
         chk($sformatf("vec%0d_record", i), g[0][4], 64'(tv[i].rec));
         chk($sformatf("vec%0d_iter", i), g[0][2], 64'(tv[i].it));
         chk($sformatf("vec%0d_status", i), g[0][5], 64'(tv[i].st));
         if (tv[i].seed == 32'd27) begin
            chk("shortcut27_cycles", g[1][0], 64'd71);
            chk("shortcut27_count", g[1][3], 64'd111);
            chk("shortcut27_record", g[1][4], 64'h2410);
            chk("olen8_27_status", g[2][5], 64'h0);
         end
      end

      run(32'd6171, 0);
      chk("olen8_6171_timeout", g[2][5], 64'h2);

      run(32'd27, 10);
      chk("abort_count", g[0][3], 64'd9);
      chk("abort_done", g[0][1], 64'd0);
      chk("abort_busy_cycles", g[0][0], 64'd10);

      for (int a = 0; a < 4; a++) begin
         wr_en = 1'b1; wr_addr = 2'(a); wr_data = (a == 0) ? 8'd27 : 8'd0;
         tick();
      end
      wr_en = 1'b0; rd_sel = 2'd1; rd_addr = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      guard = 1;
      while (guard < 50 && ia.busy) begin
         tick();
         guard++;
      end
      chk("pre_reset_busy", 64'(ia.busy), 64'h1);
      #2 rst_n = 1'b0;
      #1 chk_outs_zero("midrun_reset");
      #4 rst_n = 1'b1;
      tick();
      chk_regs_zero("midrun_reset_regs");
      run(32'd6, 0);
      chk("post_reset_count", g[0][3], 64'd8);
      chk("post_reset_record", g[0][4], 64'h0010);

      for (int i = 0; i < 20; i++) begin
         seed = (i % 3 == 0) ? 32'($urandom_range(0, 60)) : 32'($urandom);
         lim = (i % 5 == 4) ? int'($urandom_range(2, 8)) : 0;
         run(seed, lim);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
